// File: rtl/ms_uart_pkg.sv
// ms_uart_pkg: shared state encoding and constants for the UART TX arbiter
package ms_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic [7:0] HDR_BASE = 8'hA0;
    localparam int         MAX_NREQ = 8;

endpackage

// File: rtl/ms_uart_rr_pick.sv
// ms_uart_rr_pick: combinational round-robin winner search starting at the rotation pointer
module ms_uart_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         win,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any_valid
);
    import ms_uart_pkg::*;

    localparam int PW = $clog2(NREQ);

    logic [PW:0] pos;
    logic        found;

    // Walk the requesters in rotation order and keep the first valid one
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr} + (PW+1)'(k);
            pos = (pos >= (PW+1)'(NREQ)) ? pos - (PW+1)'(NREQ) : pos;
            if (!found && req_valid[pos[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = pos[PW-1:0];
            end
        end
        win       = found ? (NREQ'(1) << win_idx) : '0;
        any_valid = found;
    end

endmodule

// File: rtl/ms_uart_tx_arb.sv
// ms_uart_tx_arb: round-robin arbiter sharing the UART TX FIFO write port among NREQ byte streams
// Optional per-grant header byte (8'hA0 | requester) enabled by defining UART_TX_ARB_HDR_EN
module ms_uart_tx_arb
    import ms_uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              ENABLE,
    input  logic [NREQ-1:0]   REQ_VALID,
    input  logic [NREQ*8-1:0] REQ_DATA,
    input  logic [NREQ-1:0]   REQ_LAST,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic              FIFO_FULL,
    output logic              FIFO_WR,
    output logic [7:0]        FIFO_DIN,
    output logic [NREQ-1:0]   GRANT,
    output logic              BUSY
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;
    logic            any_valid;
    logic            in_xfer;
    logic            xfer;
    logic            hdr_wr;
    logic            burst_hit;
    logic [7:0]      sel_data;

    ms_uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid (REQ_VALID),
        .rr_ptr    (rr_ptr_q),
        .win       (win),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    // Steer the granted stream (or its header) onto the FIFO write port; idle drives zero
    always_comb begin
        sel_data  = REQ_DATA[gidx_q*8 +: 8];
        in_xfer   = state_q == ST_XFER;
        xfer      = in_xfer && !FIFO_FULL && REQ_VALID[gidx_q];
`ifdef UART_TX_ARB_HDR_EN
        hdr_wr    = (state_q == ST_HDR) && !FIFO_FULL;
        FIFO_DIN  = (state_q == ST_HDR) ? (HDR_BASE | 8'(gidx_q)) : in_xfer ? sel_data : 8'h00;
`else
        hdr_wr    = 1'b0;
        FIFO_DIN  = in_xfer ? sel_data : 8'h00;
`endif
        FIFO_WR   = xfer || hdr_wr;
        REQ_READY = (in_xfer && !FIFO_FULL) ? grant_q : '0;
        burst_hit = (MAX_BURST != 0) && (cnt_q + 1'b1 == CW'(MAX_BURST));
        GRANT     = grant_q;
        BUSY      = state_q != ST_IDLE;
    end

    // Arbitrate in IDLE, count payload bytes in XFER and release on LAST or burst limit
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (state_q == ST_IDLE) begin
            if (ENABLE && any_valid) begin
                grant_d = win;
                gidx_d  = win_idx;
                cnt_d   = '0;
`ifdef UART_TX_ARB_HDR_EN
                state_d = ST_HDR;
`else
                state_d = ST_XFER;
`endif
            end
`ifdef UART_TX_ARB_HDR_EN
        end else if (state_q == ST_HDR) begin
            state_d = FIFO_FULL ? ST_HDR : ST_XFER;
`endif
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (REQ_LAST[gidx_q] || burst_hit) begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                cnt_d    = '0;
                rr_ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
            end
        end
    end

    // State registers; reset aborts any packet in flight immediately
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ms_uart_tx_arb.sv
// tb_ms_uart_tx_arb: directed and randomized checks of the UART TX arbiter against a packet-level model
`timescale 1ns/1ps
module tb_ms_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 4;
`ifdef UART_TX_ARB_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam int GAP = HDR_EN ? 3 : 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b1;
    logic [N-1:0]   vld   = '0;
    logic [N-1:0]   last  = '0;
    logic [N*8-1:0] data  = '0;
    logic           full  = 1'b0;
    logic [N-1:0]   rdy;
    logic [N-1:0]   grant;
    logic           wr;
    logic           busy;
    logic [7:0]     din;

    ms_uart_tx_arb #(.NREQ(N), .MAX_BURST(MB)) dut (
        .CLK       (clk),
        .RESETN    (rst_n),
        .ENABLE    (en),
        .REQ_VALID (vld),
        .REQ_DATA  (data),
        .REQ_LAST  (last),
        .REQ_READY (rdy),
        .FIFO_FULL (full),
        .FIFO_WR   (wr),
        .FIFO_DIN  (din),
        .GRANT     (grant),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    // producer queues: head byte is what each requester currently offers
    logic [7:0] dq[N][$];
    bit         lq[N][$];
    int         vpct = 100;
    int         fpct = 0;
    bit         force_full = 1'b0;

    int checks = 0;
    int errors = 0;

    // model: current owner (-1 none), rotation start, bytes this grant, header pending
    int owner = -1;
    int ptr   = 0;
    int cnt   = 0;
    bit hdr   = 1'b0;

    int         cycn    = 0;
    int         fullbad = 0;
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         glog[$];
    int         gcyc[$];
    logic [N-1:0] pgrant = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cycn);
        end
    endtask

    function automatic bit pending();
        for (int r = 0; r < N; r++) if (dq[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            vld[r]          = dq[r].size() > 0 && int'($urandom_range(99)) < vpct;
            data[r*8 +: 8]  = dq[r].size() > 0 ? dq[r][0] : 8'($urandom);
            last[r]         = dq[r].size() > 0 ? lq[r][0] : 1'($urandom);
        end
        full = force_full || int'($urandom_range(99)) < fpct;
    endtask

    task automatic evaluate();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ew;
        logic [7:0]   ed;
        logic [7:0]   pd;
        bit           l;
        if (!rst_n) begin
            owner  = -1;
            ptr    = 0;
            cnt    = 0;
            hdr    = 1'b0;
            pgrant = '0;
            chk("rst_grant", 32'(grant), 0);
            chk("rst_ready", 32'(rdy), 0);
            chk("rst_wr", 32'(wr), 0);
            chk("rst_din", 32'(din), 0);
            chk("rst_busy", 32'(busy), 0);
            return;
        end
        eg = owner < 0 ? '0 : (N'(1) << owner);
        if (owner < 0) begin
            er = '0;
            ew = 1'b0;
            ed = 8'h00;
        end else if (hdr) begin
            er = '0;
            ew = !full;
            ed = 8'hA0 | 8'(owner);
        end else begin
            er = full ? '0 : eg;
            ew = vld[owner] && !full;
            ed = data[owner*8 +: 8];
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("ready", 32'(rdy), 32'(er));
        chk("fifo_wr", 32'(wr), 32'(ew));
        if (owner < 0 || !hdr || ew) chk("fifo_din", 32'(din), 32'(ed));
        if (wr) begin
            wlog.push_back(din);
            wcyc.push_back(cycn);
        end
        if (grant != 0 && pgrant == 0) begin
            for (int r = 0; r < N; r++) if (grant[r]) glog.push_back(r);
            gcyc.push_back(cycn);
        end
        pgrant = grant;
        if (full && (wr || rdy != 0)) fullbad++;
        if (owner < 0) begin
            if (en && vld != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (vld[(ptr + k) % N]) begin
                        owner = (ptr + k) % N;
                        break;
                    end
                end
                cnt = 0;
                hdr = HDR_EN;
            end
        end else if (hdr) begin
            if (!full) hdr = 1'b0;
        end else if (ew) begin
            pd = dq[owner].pop_front();
            l  = lq[owner].pop_front();
            cnt++;
            if (l || (MB != 0 && cnt == MB)) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 drive();
            @(negedge clk);
            cycn++;
            evaluate();
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(int r, logic [7:0] b, bit l);
        dq[r].push_back(b);
        lq[r].push_back(l);
    endtask

    task automatic clr();
        wlog.delete();
        wcyc.delete();
        glog.delete();
        gcyc.delete();
        fullbad = 0;
    endtask

    task automatic drain(string nm, int budget);
        int n = 0;
        while ((owner >= 0 || pending()) && n < budget) begin
            cyc(1);
            n++;
        end
        chk({nm, "_drain"}, 32'(n < budget), 1);
        cyc(1);
    endtask

    task automatic cmp_log(string nm, input logic [7:0] e[$]);
        chk({nm, "_len"}, wlog.size(), e.size());
        for (int i = 0; i < e.size() && i < wlog.size(); i++) chk(nm, 32'(wlog[i]), 32'(e[i]));
    endtask

    task automatic cmp_glog(string nm, input int e[$]);
        chk({nm, "_len"}, glog.size(), e.size());
        for (int i = 0; i < e.size() && i < glog.size(); i++) chk(nm, glog[i], e[i]);
    endtask

    initial begin
        logic [7:0] e[$];
        int         g[$];
        int         np;
        int         r;
        int         len;
        cyc(3);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wr", 32'(wr), 0);
        chk("reset_din", 32'(din), 0);
        chk("reset_ready", 32'(rdy), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1);

        clr();
        push(0, 8'h01, 1'b1);
        push(0, 8'h05, 1'b1);
        push(1, 8'h02, 1'b1);
        push(2, 8'h03, 1'b1);
        push(3, 8'h04, 1'b1);
        drain("rr", 200);
        e.delete();
        for (int i = 0; i < 5; i++) begin
            if (HDR_EN) e.push_back(8'hA0 | 8'(i % 4));
            e.push_back(8'(i + 1));
        end
        cmp_log("rr_data", e);
        g = {0, 1, 2, 3, 0};
        cmp_glog("rr_order", g);
        for (int i = 1; i < gcyc.size(); i++) chk("rr_gap", gcyc[i] - gcyc[i-1], GAP);

        clr();
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        drain("single", 200);
        e.delete();
        if (HDR_EN) e.push_back(8'hA1);
        e.push_back(8'h11);
        e.push_back(8'h22);
        e.push_back(8'h33);
        cmp_log("single_data", e);
        g = {1};
        cmp_glog("single_grant", g);
        chk("single_consec", (wcyc.size() >= 3) ? wcyc[$] - wcyc[wcyc.size()-3] : -1, 2);
        chk("single_release", 32'(grant), 0);

        clr();
        push(0, 8'h0A, 1'b1);
        push(2, 8'h0B, 1'b1);
        drain("ptr2", 200);
        g = {2, 0};
        cmp_glog("ptr2_order", g);

        clr();
        for (int b = 1; b <= 6; b++) push(0, 8'(b), b == 6);
        cyc(3);
        push(2, 8'hC0, 1'b1);
        drain("burst", 300);
        e.delete();
        if (HDR_EN) e.push_back(8'hA0);
        for (int b = 1; b <= 4; b++) e.push_back(8'(b));
        if (HDR_EN) e.push_back(8'hA2);
        e.push_back(8'hC0);
        if (HDR_EN) e.push_back(8'hA0);
        e.push_back(8'h05);
        e.push_back(8'h06);
        cmp_log("burst_data", e);
        g = {0, 2, 0};
        cmp_glog("burst_order", g);

        clr();
        for (int b = 1; b <= 4; b++) push(3, 8'h30 + 8'(b), b == 4);
        cyc(3);
        force_full = 1'b1;
        cyc(5);
        force_full = 1'b0;
        drain("full", 300);
        e.delete();
        if (HDR_EN) e.push_back(8'hA3);
        for (int b = 1; b <= 4; b++) e.push_back(8'h30 + 8'(b));
        cmp_log("full_data", e);
        chk("full_no_write", fullbad, 0);

        clr();
        push(3, 8'h55, 1'b1);
        push(0, 8'h66, 1'b1);
        drain("rot", 200);
        e.delete();
        if (HDR_EN) e.push_back(8'hA0);
        e.push_back(8'h66);
        if (HDR_EN) e.push_back(8'hA3);
        e.push_back(8'h55);
        cmp_log("rot_data", e);
        g = {0, 3};
        cmp_glog("rot_order", g);

        clr();
        for (int b = 1; b <= 4; b++) push(1, 8'h40 + 8'(b), b == 4);
        cyc(3);
        chk("pre_rst_grant", 32'(grant), 32'(4'b0010));
        chk("pre_rst_busy", 32'(busy), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            dq[k].delete();
            lq[k].delete();
        end
        #1;
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_ready", 32'(rdy), 0);
        chk("midrst_wr", 32'(wr), 0);
        chk("midrst_din", 32'(din), 0);
        chk("midrst_busy", 32'(busy), 0);
        cyc(2);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1);
        clr();
        push(1, 8'h51, 1'b1);
        push(0, 8'h50, 1'b1);
        drain("postrst", 200);
        e.delete();
        if (HDR_EN) e.push_back(8'hA0);
        e.push_back(8'h50);
        if (HDR_EN) e.push_back(8'hA1);
        e.push_back(8'h51);
        cmp_log("postrst_data", e);
        g = {0, 1};
        cmp_glog("postrst_order", g);

        for (int round = 0; round < 60; round++) begin
            np = $urandom_range(3);
            for (int p = 0; p < np; p++) begin
                r   = $urandom_range(N - 1);
                len = $urandom_range(1, 7);
                for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
            end
            vpct = $urandom_range(40, 100);
            fpct = $urandom_range(0, 40);
            en   = $urandom_range(4) != 0;
            cyc($urandom_range(3, 25));
        end
        vpct = 100;
        fpct = 0;
        en   = 1'b1;
        drain("random", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
